// File: rtl/mux4_scanner_if.sv
// Scanner bundle: start/busy/done handshake, snapshot result, and the mux select/output pair.
interface mux4_scanner_if;
  logic       start;
  logic [3:0] en_mask;
  logic       outp;
  logic [1:0] s;
  logic       busy;
  logic       done;
  logic [3:0] sample;

  modport master (output start, en_mask, outp, input s, busy, done, sample);
  modport slave  (input start, en_mask, outp, output s, busy, done, sample);
endinterface

// File: rtl/mux4_scanner.sv
// Steps the mux4 select through enabled channels, dwelling DWELL cycles each, and snapshots outp.
// Optional macro MUX4_SCAN_AUTO_EN: start held at the completing edge re-arms with no IDLE cycle.
module mux4_scanner #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  mux4_scanner_if.slave bus
);
  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state, state_n;
  logic [1:0]       s_q, s_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [3:0]       sample_q, sample_n;
  logic [3:0]       mask_q, mask_n;
  logic [3:0]       higher;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_q      <= 2'd0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= 4'b0000;
      mask_q   <= 4'b0000;
    end else begin
      state    <= state_n;
      s_q      <= s_n;
      cnt      <= cnt_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      sample_q <= sample_n;
      mask_q   <= mask_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_n      = s_q;
    cnt_n    = cnt;
    busy_n   = busy_q;
    done_n   = 1'b0;
    sample_n = sample_q;
    mask_n   = mask_q;
    // Enabled channels strictly above the one currently selected.
    higher   = mask_q & (4'b1110 << s_q);

    case (state)
      IDLE: begin
        if (bus.start) begin
          sample_n = 4'b0000;
          if (bus.en_mask != 4'b0000) begin
            mask_n  = bus.en_mask;
            s_n     = lowest(bus.en_mask);
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = SCAN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SCAN: begin
        if (cnt != LAST) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          sample_n[s_q] = bus.outp;
          cnt_n         = '0;
          if (higher != 4'b0000) begin
            s_n = lowest(higher);
          end else begin
            done_n = 1'b1;
`ifdef MUX4_SCAN_AUTO_EN
            if (bus.start && bus.en_mask != 4'b0000) begin
              mask_n   = bus.en_mask;
              sample_n = 4'b0000;
              s_n      = lowest(bus.en_mask);
            end else begin
              busy_n  = 1'b0;
              state_n = IDLE;
            end
`else
            busy_n  = 1'b0;
            state_n = IDLE;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.s      = s_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sample = sample_q;
endmodule

// File: tb/tb_mux4_scanner.sv
// Bench for mux4_scanner: vector table, mid-scan corner sequences, randomized scans vs. a channel-list model.
module tb_mux4_scanner;
  localparam int DWELL  = 4;
  localparam int BUDGET = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mux_in;
  logic [3:0] mux_in1;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mux4_scanner_if bus();
  mux4_scanner_if bus1();

  assign bus.outp  = mux_in[bus.s];
  assign bus1.outp = mux_in1[bus1.s];

  mux4_scanner #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  mux4_scanner #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  typedef struct {
    logic [3:0] mask;
    logic [3:0] mux;
    logic [3:0] exp_sample;
    int         exp_cycles;
    string      name;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] mask, input logic [3:0] mi);
    bus.start   = st;
    bus.en_mask = mask;
    mux_in      = mi;
  endtask

  // One start pulse; the model lists enabled channels ascending and expects DWELL cycles on each.
  task automatic runScan(input logic [3:0] mask, input logic [3:0] mi, input bit vary,
                         output int cycles, output logic [3:0] got, output logic [3:0] model);
    int         chans[$];
    int         n;
    int         s_err;
    int         busy_err;
    logic [3:0] cur;
    chans    = {};
    s_err    = 0;
    busy_err = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) chans.push_back(i);
    n      = chans.size();
    model  = 4'b0000;
    cur    = mi;
    cycles = -1;
    applyStimulus(1'b1, mask, cur);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      if (bus.done === 1'b1) begin
        cycles = k;
        break;
      end
      if (k < n * DWELL) begin
        if (bus.s !== 2'(chans[k / DWELL])) s_err++;
        if (bus.busy !== 1'b1) busy_err++;
      end
      if (vary) begin
        cur    = 4'($urandom);
        mux_in = cur;
      end
      if (k < n * DWELL && (k + 1) % DWELL == 0)
        model[chans[k / DWELL]] = cur[chans[k / DWELL]];
      tick();
    end
    got = bus.sample;
    checkOutput("scan_s_sequence", s_err, 0);
    checkOutput("scan_busy_high", busy_err, 0);
    checkOutput("scan_latency", cycles, n * DWELL);
    checkOutput("done_busy_low", bus.busy, 1'b0);
    tick();
    checkOutput("done_one_cycle", bus.done, 1'b0);
    checkOutput("sample_held", bus.sample, got);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] got;
    logic [3:0] model;
    logic [3:0] m;
    int         cyc;
    int         pulses;
    int         done_err;
    int         busy_err;
    int         period;
    int         gap;
    bit         exp_done;
    bit         exp_busy;

    vecs[0] = '{4'b1111, 4'b1010, 4'b1010, 16, "full_mask"};
    vecs[1] = '{4'b0110, 4'b1010, 4'b0010, 8,  "mid_pair"};
    vecs[2] = '{4'b0001, 4'b1111, 4'b0001, 4,  "only_ch0"};
    vecs[3] = '{4'b1000, 4'b1000, 4'b1000, 4,  "only_ch3"};
    vecs[4] = '{4'b1001, 4'b0110, 4'b0000, 8,  "ends_low_in"};
    vecs[5] = '{4'b0101, 4'b0101, 4'b0101, 8,  "alternate"};
    vecs[6] = '{4'b0000, 4'b1111, 4'b0000, 0,  "empty_mask"};

    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    bus1.start   = 1'b0;
    bus1.en_mask = 4'b0000;
    mux_in1      = 4'b0000;
    tick();
    tick();
    checkOutput("reset_s", bus.s, 2'd0);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_done", bus.done, 1'b0);
    checkOutput("reset_sample", bus.sample, 4'b0000);
    checkOutput("reset_busy_dwell1", bus1.busy, 1'b0);
    checkOutput("reset_s_dwell1", bus1.s, 2'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      runScan(vecs[i].mask, vecs[i].mux, 1'b0, cyc, got, model);
      checkOutput({vecs[i].name, "_sample"}, got, vecs[i].exp_sample);
      checkOutput({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cycles);
    end

    // Start and a new mask arriving mid-scan must not disturb the running scan.
    applyStimulus(1'b1, 4'b1111, 4'b1010);
    tick();
    cyc = -1;
    for (int k = 0; k < BUDGET; k++) begin
      if (bus.done === 1'b1) begin
        cyc = k;
        break;
      end
      if (k == 4) begin
        bus.start   = 1'b1;
        bus.en_mask = 4'b0001;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    checkOutput("busy_start_ignored_cycles", cyc, 16);
    checkOutput("busy_start_ignored_sample", bus.sample, 4'b1010);
    checkOutput("last_channel_held", bus.s, 2'd3);
    tick();
    checkOutput("no_rescan_after_done", bus.busy, 1'b0);

    // Reset at edge 9 of a full scan aborts it with no done pulse.
    applyStimulus(1'b1, 4'b1111, 4'b1010);
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_s", bus.s, 2'd0);
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_sample", bus.sample, 4'b0000);
    checkOutput("abort_done", bus.done, 1'b0);
    rst    = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    checkOutput("abort_stays_idle", pulses, 0);
    runScan(4'b0110, 4'b1010, 1'b0, cyc, got, model);
    checkOutput("after_abort_sample", got, 4'b0010);

    for (int r = 0; r < 16; r++) begin
      m = 4'($urandom);
      runScan(m, 4'($urandom), 1'b1, cyc, got, model);
      checkOutput("random_sample", got, model);
    end

    // DWELL=1 with start held high: back-to-back scans, with or without the re-arm option.
`ifdef MUX4_SCAN_AUTO_EN
    gap = 0;
`else
    gap = 1;
`endif
    period       = 4 + gap;
    done_err     = 0;
    busy_err     = 0;
    mux_in1      = 4'b0110;
    bus1.en_mask = 4'b1111;
    bus1.start   = 1'b1;
    tick();
    for (int k = 1; k <= 14; k++) begin
      tick();
      exp_done = ((k % period) == (4 % period));
      exp_busy = (gap == 0) ? 1'b1 : !exp_done;
      if (bus1.done !== exp_done) done_err++;
      if (bus1.busy !== exp_busy) busy_err++;
      if (gap != 0 && exp_done && bus1.sample !== (bus1.en_mask & mux_in1)) done_err++;
    end
    bus1.start = 1'b0;
    checkOutput("held_start_done_pattern", done_err, 0);
    checkOutput("held_start_busy_pattern", busy_err, 0);
    repeat (8) tick();
    checkOutput("held_start_drains", bus1.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux4_scanner.md
Name: mux4_scanner

Overview:
Sequencer placed directly upstream of the 4:1 mux (mux4). Drives the mux select `s` through the enabled channels in ascending order. Holds each channel for a programmable dwell, then samples the mux output `outp` into a 4-bit result register. Uses a start/busy/done handshake so a controller or bench can read all four mux inputs as one snapshot.

Parameters:
DWELL, 4, cycles `s` is held per channel; legal range 1..2^CNT_W.
CNT_W, 8, width of the dwell counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  scan request, sampled only in IDLE
en_mask  input  4  channel enable; bit i enables channel i; latched on accepted start
outp  input  1  mux output (combinational from s)
s  output  2  mux select, registered
busy  output  1  high from accepted start until the scan completes
done  output  1  one-cycle pulse: scan complete, sample valid
sample  output  4  bit i = outp captured while s==i; 0 for disabled channels

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, s=0, cnt=0, busy=0, done=0, sample=4'b0000, mask_q=0.
  - Reset mid-scan aborts immediately; no done pulse.
- FSM states: IDLE, SCAN.
- IDLE, start=1, en_mask!=0:
  - mask_q<=en_mask, sample<=0.
  - s<=lowest set bit of en_mask, cnt<=0, busy<=1.
  - Go to SCAN.
- IDLE, start=1, en_mask==0:
  - sample<=0, done<=1 for one cycle, busy stays 0.
  - Stay in IDLE.
- SCAN, cnt<DWELL-1: cnt<=cnt+1, s held.
- SCAN, cnt==DWELL-1:
  - sample[s]<=outp.
  - If a higher enabled channel remains in mask_q: s<=next enabled channel, cnt<=0.
  - Otherwise: done<=1, busy<=0, go to IDLE. s keeps the last channel.
- done is a registered pulse, exactly one cycle wide. It is high in the cycle following the final capture edge, and sample is stable and valid while done=1.
- Latency: N enabled channels, start accepted at edge E → final capture and done set at edge E+N*DWELL.
- start while busy: ignored. en_mask changes while busy: ignored (mask_q is used).
- sample holds its value until the next accepted start or reset.
- Counter wrap: cnt never exceeds DWELL-1. DWELL=1 means one cycle per channel.

Optional Feature:
Macro MUX4_SCAN_AUTO_EN.
- Defined: at the completing edge of SCAN, if start=1, the block re-arms immediately.
  - mask_q<=en_mask, sample<=0, s<=first enabled channel, cnt<=0.
  - busy stays 1, done still pulses, no IDLE cycle.
  - Holding start high gives back-to-back scans every N*DWELL cycles.
  - If the new en_mask==0, go to IDLE with busy<=0.
- Not defined: start at the completing edge is ignored. At least one IDLE cycle separates scans; start is sampled only in IDLE.

Test Plan:
1. Mux inputs a=0,b=1,c=0,d=1, DWELL=4, en_mask=4'b1111, start pulsed at edge 0:
   - s steps 0,1,2,3 each held 4 cycles.
   - done high one cycle after edge 16, sample=4'b1010, busy 1 during edges 0..16.
2. Same inputs, en_mask=4'b0110:
   - s visits 1 then 2 only.
   - done after edge 8, sample=4'b0010.
3. en_mask=4'b0000 with start → done pulse on the next cycle, busy never 1, sample=0.
4. start re-pulsed and en_mask changed to 4'b0001 at edge 5 of scan 1 → ignored; scan 1 result still 4'b1010 at edge 16.
5. rst asserted at edge 9 of a full scan → next cycle s=0, busy=0, sample=0, no done pulse. A new start then completes normally.
6. MUX4_SCAN_AUTO_EN defined, start held high, DWELL=1, mask=4'b1111:
   - done pulses at edges 4, 8, 12; busy never drops.
   - Without the macro: done at edge 4 only, next scan starts from IDLE at edge 5, done at edge 9.
